// File: rtl/manchester_framer.sv
// Byte framer feeding the Manchester serializer. Each frame is PREAMBLE_LEN
// bytes of 0xAA, one 0xD5 start-of-frame delimiter, FRAME_SIZE payload bytes
// taken from the s_axis side, an optional CRC-8 byte, then GAP_CYCLES idle
// cycles before the next frame may start.
//
// Optional feature: define MANCHESTER_FRAMER_CRC_EN to append a CRC-8 byte
// (poly 0x07, init 0x00, MSB first, no reflection, no final XOR) computed over
// the payload bytes only.
//
// Ports:
//   aclk, areset             clock (rising edge), async active-high reset
//   s_axis_tdata/tvalid/tready  payload byte stream in
//   m_axis_tdata/tvalid/tready  framed byte stream out (registered)
//   busy                     high whenever the FSM is not idle
//   frame_count              completed frames, wraps at 16 bits
module manchester_framer #(
  parameter int unsigned FRAME_SIZE   = 4,
  parameter int unsigned PREAMBLE_LEN = 2,
  parameter int unsigned GAP_CYCLES   = 0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StPayload,
    StGap
`ifdef MANCHESTER_FRAMER_CRC_EN
    , StCrc
`endif
  } state_e;

  localparam logic [3:0] PreLast  = 4'(PREAMBLE_LEN - 1);
  localparam logic [7:0] ByteLast = 8'(FRAME_SIZE - 1);
  localparam logic [7:0] GapLast  = 8'(GAP_CYCLES - 1);
  localparam state_e AfterFrame   = (GAP_CYCLES > 0) ? StGap : StIdle;

  state_e      state_q, state_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        slot_free;
  logic        load;
  logic [7:0]  load_byte;

`ifdef MANCHESTER_FRAMER_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  // The output register can take a new byte when empty or being drained now.
  assign slot_free     = !tvalid_q || m_axis_tready;
  assign s_axis_tready = (state_q == StPayload) && slot_free;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = (state_q != StIdle);
  assign frame_count   = frame_count_q;

  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    frame_count_d = frame_count_q;
    load          = 1'b0;
    load_byte     = 8'h00;
`ifdef MANCHESTER_FRAMER_CRC_EN
    crc_d         = crc_q;
`endif

    unique case (state_q)
      StIdle: begin
        // Start on a pending payload byte without consuming it.
        if (s_axis_tvalid && slot_free) begin
          load      = 1'b1;
          load_byte = 8'hAA;
          pre_cnt_d = 4'd1;
          state_d   = (PREAMBLE_LEN > 1) ? StPreamble : StSfd;
        end
      end
      StPreamble: begin
        if (slot_free) begin
          load      = 1'b1;
          load_byte = 8'hAA;
          pre_cnt_d = pre_cnt_q + 4'd1;
          if (pre_cnt_q == PreLast) state_d = StSfd;
        end
      end
      StSfd: begin
        if (slot_free) begin
          load       = 1'b1;
          load_byte  = 8'hD5;
          byte_cnt_d = 8'd0;
`ifdef MANCHESTER_FRAMER_CRC_EN
          crc_d      = 8'h00;
`endif
          state_d    = StPayload;
        end
      end
      StPayload: begin
        if (s_axis_tvalid && slot_free) begin
          load       = 1'b1;
          load_byte  = s_axis_tdata;
          byte_cnt_d = byte_cnt_q + 8'd1;
`ifdef MANCHESTER_FRAMER_CRC_EN
          crc_d      = crc8_next(crc_q, s_axis_tdata);
          if (byte_cnt_q == ByteLast) state_d = StCrc;
`else
          if (byte_cnt_q == ByteLast) begin
            frame_count_d = frame_count_q + 16'd1;
            gap_cnt_d     = 8'd0;
            state_d       = AfterFrame;
          end
`endif
        end
      end
`ifdef MANCHESTER_FRAMER_CRC_EN
      StCrc: begin
        if (slot_free) begin
          load          = 1'b1;
          load_byte     = crc_q;
          frame_count_d = frame_count_q + 16'd1;
          gap_cnt_d     = 8'd0;
          state_d       = AfterFrame;
        end
      end
`endif
      StGap: begin
        gap_cnt_d = gap_cnt_q + 8'd1;
        if (gap_cnt_q == GapLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    if (load) begin
      tdata_d  = load_byte;
      tvalid_d = 1'b1;
    end else if (slot_free) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= StIdle;
      tdata_q       <= 8'h00;
      tvalid_q      <= 1'b0;
      pre_cnt_q     <= 4'd0;
      byte_cnt_q    <= 8'd0;
      gap_cnt_q     <= 8'd0;
      frame_count_q <= 16'd0;
`ifdef MANCHESTER_FRAMER_CRC_EN
      crc_q         <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      pre_cnt_q     <= pre_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_count_q <= frame_count_d;
`ifdef MANCHESTER_FRAMER_CRC_EN
      crc_q         <= crc_d;
`endif
    end
  end

endmodule
